// File: rtl/clk_div_ctrl.sv
// Run/stop controller for a glitch-free programmable divided clock with tick enable.
// Optional CLK_DIV_CTRL_PERIOD_CNT_EN adds a 16-bit period_cnt output counting ticks.
module clk_div_ctrl #(
  parameter int CNT_W       = 26,
  parameter int DEFAULT_DIV = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             div_ack,
  output logic             busy,
  output logic             CLK,
  output logic             tick
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  ,
  output logic [15:0]      period_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active;
  logic [CNT_W-1:0] shadow;
  logic             pending;

  logic [CNT_W-1:0] load_val;
  logic             last;
  logic             rise;
  logic             apply;

  always_comb begin
    load_val = (div_val == '0) ? CNT_W'(1) : div_val;
    last     = (cnt == active - CNT_W'(1));
    // A rising edge of CLK happens leaving IDLE, or at the end of a low phase
    // unless we are draining with en still low.
    rise     = 1'b0;
    if (state == IDLE)
      rise = en;
    else if (last && !CLK)
      rise = (state == RUN) || en;
    // New ratios only land at a period boundary so each period uses one ratio.
    apply    = pending && ((state == IDLE) || rise);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      active  <= DEF_DIV;
      shadow  <= DEF_DIV;
      pending <= 1'b0;
      CLK     <= 1'b0;
      tick    <= 1'b0;
      div_ack <= 1'b0;
      busy    <= 1'b0;
    end else begin
      tick    <= rise;
      div_ack <= apply;
      if (apply) begin
        active  <= shadow;
        pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          CLK <= 1'b0;
          if (en) begin
            state <= RUN;
            busy  <= 1'b1;
            CLK   <= 1'b1;
          end
        end
        RUN, DRAIN: begin
          if (last) begin
            cnt <= '0;
            if (CLK)
              CLK <= 1'b0;
            else if (rise)
              CLK <= 1'b1;
            else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
          if (state == RUN && !en)
            state <= DRAIN;
          else if (state == DRAIN && en)
            state <= RUN;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // A load on the same edge as an apply wins, keeping the new value pending.
      if (div_load) begin
        shadow  <= load_val;
        pending <= 1'b1;
      end
    end
  end

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      period_cnt <= 16'd0;
    else if (rise)
      period_cnt <= period_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed, table-driven testbench for clk_div_ctrl with DEFAULT_DIV=4.
module tb_clk_div_ctrl;

  localparam int CNT_W = 26;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [CNT_W-1:0] div_val;
  logic             div_load;
  logic             div_ack;
  logic             busy;
  logic             CLK;
  logic             tick;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  logic [15:0]      period_cnt;
`endif

  clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .div_ack  (div_ack),
    .busy     (busy),
    .CLK      (CLK),
    .tick     (tick)
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    ,
    .period_cnt (period_cnt)
`endif
  );

  always #10 clk = ~clk;

  typedef struct {
    logic             en;
    logic             ld;
    logic [CNT_W-1:0] val;
    logic             e_clk;
    logic             e_tick;
    logic             e_busy;
    logic             e_ack;
  } vec_t;

  vec_t vecs[$];
  int   total  = 0;
  int   passed = 0;

  function automatic void add(logic e, logic l, int v, logic c, logic t, logic b, logic a);
    vec_t r;
    r.en = e; r.ld = l; r.val = CNT_W'(v);
    r.e_clk = c; r.e_tick = t; r.e_busy = b; r.e_ack = a;
    vecs.push_back(r);
  endfunction

  task automatic chk(string name, int idx, logic act, logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
  endtask

  task automatic chk_all(string tag, int idx, logic c, logic t, logic b, logic a);
    chk({tag, ".CLK"}, idx, CLK, c);
    chk({tag, ".tick"}, idx, tick, t);
    chk({tag, ".busy"}, idx, busy, b);
    chk({tag, ".div_ack"}, idx, div_ack, a);
    $display("%s step %0d: en=%b ld=%b CLK=%b tick=%b busy=%b ack=%b",
             tag, idx, en, div_load, CLK, tick, busy, div_ack);
  endtask

  initial begin
    // Start, 4/4 periods, then load 2 mid high-phase.
    add(1,0,0, 1,1,1,0);
    add(1,0,0, 1,0,1,0);
    add(1,1,2, 1,0,1,0);
    add(1,0,0, 1,0,1,0);
    for (int i = 0; i < 4; i++) add(1,0,0, 0,0,1,0);
    add(1,0,0, 1,1,1,1);
    add(1,0,0, 1,0,1,0);
    add(1,0,0, 0,0,1,0);
    add(1,0,0, 0,0,1,0);
    add(1,0,0, 1,1,1,0);
    // Two loads (6 then 3) within one period: single ack, 3/3 follows.
    add(1,1,6, 1,0,1,0);
    add(1,0,0, 0,0,1,0);
    add(1,1,3, 0,0,1,0);
    add(1,0,0, 1,1,1,1);
    add(1,0,0, 1,0,1,0);
    add(1,0,0, 1,0,1,0);
    for (int i = 0; i < 3; i++) add(1,0,0, 0,0,1,0);
    add(1,0,0, 1,1,1,0);
    // en dropped mid high-phase: finish high and low, then IDLE.
    add(0,0,0, 1,0,1,0);
    add(0,0,0, 1,0,1,0);
    for (int i = 0; i < 3; i++) add(0,0,0, 0,0,1,0);
    add(0,0,0, 0,0,0,0);
    add(0,0,0, 0,0,0,0);
    // Load 0 in IDLE: treated as 1, ack next cycle, then period 2.
    add(0,1,0, 0,0,0,0);
    add(0,0,0, 0,0,0,1);
    add(0,0,0, 0,0,0,0);
    add(1,0,0, 1,1,1,0);
    add(1,0,0, 0,0,1,0);
    add(1,0,0, 1,1,1,0);
    add(1,0,0, 0,0,1,0);
    add(1,0,0, 1,1,1,0);

    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_val = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    chk("reset.period_cnt", 0, period_cnt == 16'd0, 1'b1);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      en = vecs[i].en; div_load = vecs[i].ld; div_val = vecs[i].val;
      @(posedge clk);
      #1;
      chk_all("vec", i + 1, vecs[i].e_clk, vecs[i].e_tick, vecs[i].e_busy, vecs[i].e_ack);
    end
    div_load = 1'b0;

    // Asynchronous reset while CLK is high, checked before any clock edge.
    #5 rst = 1'b1;
    #1 chk_all("async_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    chk("async_rst.period_cnt", 0, period_cnt == 16'd0, 1'b1);
`endif
    @(negedge clk);
    rst = 1'b0;

    // After reset the active ratio is 4 again: 4 high, 4 low, then rise.
    en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      chk_all("post_rst", i, (i < 4) || (i == 8), (i == 0) || (i == 8), 1'b1, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
